// File: rtl/bus_ep_pkg.sv
// -----------------------------------------------------------------------------
// bus_ep_pkg
// Shared definitions for the broadcast-bus endpoint:
//   ID_W        width of the destination ID held in the top bits of a packet
//   MAX_PKT_W   widest packet the helper functions accept (callers zero-extend)
//   dest_id()   extracts the destination ID from a packet of any width >= ID_W
//   is_for_me() address filter: destination equals own ID or broadcast ID
// -----------------------------------------------------------------------------
package bus_ep_pkg;

    localparam int ID_W      = 8;
    localparam int MAX_PKT_W = 256;

    // The packet is passed zero-extended to MAX_PKT_W so one function serves
    // every pckg_sz; the real width selects where the ID field sits.
    function automatic logic [ID_W-1:0] dest_id(
        input logic [MAX_PKT_W-1:0] pkt,
        input int                   pkt_w
    );
        logic [MAX_PKT_W-1:0] shifted;
        shifted = pkt >> (pkt_w - ID_W);
        return shifted[ID_W-1:0];
    endfunction

    function automatic logic is_for_me(
        input logic [MAX_PKT_W-1:0] pkt,
        input int                   pkt_w,
        input logic [ID_W-1:0]      my_id,
        input logic [ID_W-1:0]      bcast_id
    );
        logic [ID_W-1:0] dst;
        dst = dest_id(pkt, pkt_w);
        return (dst == my_id) || (dst == bcast_id);
    endfunction

endpackage

// File: rtl/ep_sync_fifo.sv
// -----------------------------------------------------------------------------
// ep_sync_fifo
// Show-ahead synchronous FIFO with a registered head output.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   push, din       write request / data (ignored when full unless popping)
//   pop             read request (ignored when empty)
//   dout            registered head; holds its last value once the FIFO empties
//   full, empty     status from registered pointers
//   count           current occupancy
// -----------------------------------------------------------------------------
module ep_sync_fifo
    import bus_ep_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [PW-1:0]    rd_ptr_next;
    logic [WIDTH-1:0] dout_reg;
    logic             do_push, do_pop;

    // Extra pointer MSB tells a full FIFO from an empty one.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign count = wr_ptr_reg - rd_ptr_reg;

    assign do_pop      = pop && !empty;
    // A pop in the same cycle frees the slot a write into a full FIFO needs.
    assign do_push     = push && (!full || do_pop);
    assign rd_ptr_next = rd_ptr_reg + PW'(1);
    assign dout        = dout_reg;

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            dout_reg   <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)
                rd_ptr_reg <= rd_ptr_next;

            // Keep the head register equal to the entry at the new read pointer.
            if (do_pop) begin
                if (count == PW'(1)) begin
                    // Last entry leaves: a same-cycle write becomes the head,
                    // otherwise the old value is held.
                    if (do_push)
                        dout_reg <= din;
                end else begin
                    dout_reg <= mem[rd_ptr_next[AW-1:0]];
                end
            end else if (empty && do_push) begin
                dout_reg <= din;
            end
        end
    end

endmodule

// File: rtl/bus_endpoint.sv
// -----------------------------------------------------------------------------
// bus_endpoint
// Responder end of the shared broadcast bus, one per driver slot.
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   pndng, D_pop, pop        TX side toward the bus arbiter
//   push, D_push             packets delivered by the bus
//   tx_valid/tx_ready/tx_data host -> TX FIFO handshake
//   rx_valid/rx_ready/rx_data RX FIFO -> host handshake
//   rx_drop_cnt              accepted packets lost to a full RX FIFO (saturating)
//   err_underflow            sticky: pop while nothing was pending
// pckg_sz must lie between ID_W and MAX_PKT_W.
// -----------------------------------------------------------------------------
module bus_endpoint
    import bus_ep_pkg::*;
#(
    parameter int              pckg_sz   = 16,
    parameter int              depth     = 8,
    parameter logic [ID_W-1:0] id        = 8'h00,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [pckg_sz-1:0] rx_data,
    output logic [7:0]         rx_drop_cnt,
    output logic               err_underflow
);

    localparam int CW = $clog2(depth) + 1;

    logic                 tx_full, tx_empty;
    logic                 rx_full, rx_empty;
    logic [CW-1:0]        tx_count_unused, rx_count_unused;
    logic [MAX_PKT_W-1:0] d_push_ext;
    logic                 rx_accept;
    logic                 rx_drop;
    logic [7:0]           rx_drop_cnt_reg;
    logic                 err_underflow_reg;

    assign d_push_ext = MAX_PKT_W'(D_push);
    assign rx_accept  = push && is_for_me(d_push_ext, pckg_sz, id, broadcast);
    // Full with no same-cycle host read: nowhere to put the packet.
    assign rx_drop    = rx_accept && rx_full && !rx_ready;

    assign tx_ready      = !tx_full;
    assign pndng         = !tx_empty;
    assign rx_valid      = !rx_empty;
    assign rx_drop_cnt   = rx_drop_cnt_reg;
    assign err_underflow = err_underflow_reg;

    ep_sync_fifo #(.WIDTH(pckg_sz), .DEPTH(depth)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_valid && !tx_full),
        .pop   (pop),
        .din   (tx_data),
        .dout  (D_pop),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count_unused)
    );

    ep_sync_fifo #(.WIDTH(pckg_sz), .DEPTH(depth)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_accept),
        .pop   (rx_ready),
        .din   (D_push),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count_unused)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_drop_cnt_reg   <= '0;
            err_underflow_reg <= 1'b0;
        end else begin
            if (rx_drop && rx_drop_cnt_reg != 8'hFF)
                rx_drop_cnt_reg <= rx_drop_cnt_reg + 8'd1;
            if (pop && tx_empty)
                err_underflow_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_endpoint.sv
module tb_bus_endpoint;

    logic        CLK_100MHZ = 1'b0;
    logic        reset;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop;
    logic        push;
    logic [15:0] D_push;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] tx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] rx_data;
    logic [7:0]  rx_drop_cnt;
    logic        err_underflow;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK_100MHZ = ~CLK_100MHZ;

    bus_endpoint #(.pckg_sz(16), .depth(8), .id(8'h02), .broadcast(8'hFF)) dut (
        .clk           (CLK_100MHZ),
        .reset         (reset),
        .pndng         (pndng),
        .D_pop         (D_pop),
        .pop           (pop),
        .push          (push),
        .D_push        (D_push),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_drop_cnt   (rx_drop_cnt),
        .err_underflow (err_underflow)
    );

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge CLK_100MHZ);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; pop = 0; push = 0; D_push = '0;
        tx_valid = 0; tx_data = '0; rx_ready = 0;
        repeat (3) tick();
        vectors++;
        if ({pndng, rx_valid, tx_ready, err_underflow} !== 4'b0010) begin
            miscompares++;
            $display("FAIL reset_flags: got pndng/rx_valid/tx_ready/err=%b, expected 0010",
                     {pndng, rx_valid, tx_ready, err_underflow});
        end
        vectors++;
        if ({D_pop, rx_data, rx_drop_cnt} !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_data: got D_pop=%h rx_data=%h drop=%0d, expected all 0",
                     D_pop, rx_data, rx_drop_cnt);
        end
        reset = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_tx_order();
        tx_valid = 1; tx_data = 16'h0201;
        tick();
        vectors++;
        if (pndng !== 1'b1 || D_pop !== 16'h0201) begin
            miscompares++;
            $display("FAIL tx_first: got pndng=%b D_pop=%h, expected 1 0201", pndng, D_pop);
        end
        tx_data = 16'h0302;
        tick();
        tx_valid = 0;
        pop = 1;
        tick();
        pop = 0;
        vectors++;
        if (pndng !== 1'b1 || D_pop !== 16'h0302) begin
            miscompares++;
            $display("FAIL tx_second: got pndng=%b D_pop=%h, expected 1 0302", pndng, D_pop);
        end
        pop = 1;
        tick();
        pop = 0;
        vectors++;
        if (pndng !== 1'b0 || D_pop !== 16'h0302 || err_underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL tx_drained: got pndng=%b D_pop=%h err=%b, expected 0 0302 0",
                     pndng, D_pop, err_underflow);
        end
        $display("test_tx_order done");
    endtask

    task automatic test_tx_full();
        for (int i = 0; i < 8; i++) begin
            tx_valid = 1; tx_data = 16'(16'h1000 + i);
            tick();
            if (i == 6) begin
                vectors++;
                if (tx_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL tx_seven: got tx_ready=%b, expected 1", tx_ready);
                end
            end
        end
        tx_valid = 0;
        vectors++;
        if (tx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL tx_full: got tx_ready=%b, expected 0", tx_ready);
        end
        // Offer a write and pop together: the write is refused this cycle.
        tx_valid = 1; tx_data = 16'hBEEF; pop = 1;
        #2;
        vectors++;
        if (tx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL tx_ready_hold: got tx_ready=%b, expected 0", tx_ready);
        end
        tick();
        tx_valid = 0;
        for (int i = 1; i < 8; i++) begin
            vectors++;
            if (pndng !== 1'b1 || D_pop !== 16'(16'h1000 + i)) begin
                miscompares++;
                $display("FAIL tx_order_%0d: got pndng=%b D_pop=%h, expected 1 %h",
                         i, pndng, D_pop, 16'(16'h1000 + i));
            end
            tick();
        end
        pop = 0;
        vectors++;
        if (pndng !== 1'b0 || err_underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL tx_full_drain: got pndng=%b err=%b, expected 0 0", pndng, err_underflow);
        end
        $display("test_tx_full done");
    endtask

    task automatic test_back_to_back();
        tx_valid = 1; tx_data = 16'h0A01;
        push = 1; D_push = 16'h0201; rx_ready = 0;
        tick();
        for (int i = 2; i <= 5; i++) begin
            tx_data = 16'(16'h0A00 + i); pop = 1;
            D_push  = 16'(16'h0200 + i); rx_ready = 1;
            tick();
            vectors++;
            if (pndng !== 1'b1 || D_pop !== 16'(16'h0A00 + i)) begin
                miscompares++;
                $display("FAIL b2b_tx_%0d: got pndng=%b D_pop=%h, expected 1 %h",
                         i, pndng, D_pop, 16'(16'h0A00 + i));
            end
            vectors++;
            if (rx_valid !== 1'b1 || rx_data !== 16'(16'h0200 + i)) begin
                miscompares++;
                $display("FAIL b2b_rx_%0d: got rx_valid=%b rx_data=%h, expected 1 %h",
                         i, rx_valid, rx_data, 16'(16'h0200 + i));
            end
        end
        tx_valid = 0; push = 0;
        tick();
        pop = 0; rx_ready = 0;
        vectors++;
        if (pndng !== 1'b0 || rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: got pndng=%b rx_valid=%b, expected 0 0", pndng, rx_valid);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_rx_filter();
        rx_ready = 0; push = 1;
        D_push = 16'h02AA; tick();
        D_push = 16'hFFBB; tick();
        D_push = 16'h05CC; tick();
        push = 0;
        vectors++;
        if (rx_valid !== 1'b1 || rx_data !== 16'h02AA) begin
            miscompares++;
            $display("FAIL rx_own: got rx_valid=%b rx_data=%h, expected 1 02AA", rx_valid, rx_data);
        end
        rx_ready = 1;
        tick();
        vectors++;
        if (rx_valid !== 1'b1 || rx_data !== 16'hFFBB) begin
            miscompares++;
            $display("FAIL rx_bcast: got rx_valid=%b rx_data=%h, expected 1 FFBB", rx_valid, rx_data);
        end
        tick();
        rx_ready = 0;
        vectors++;
        if (rx_valid !== 1'b0 || rx_drop_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL rx_filtered: got rx_valid=%b drop=%0d, expected 0 0", rx_valid, rx_drop_cnt);
        end
        $display("test_rx_filter done");
    endtask

    task automatic test_rx_overflow();
        rx_ready = 0; push = 1;
        for (int i = 0; i < 10; i++) begin
            D_push = 16'(16'h0200 + i);
            tick();
            if (i == 7) begin
                vectors++;
                if (rx_drop_cnt !== 8'd0) begin
                    miscompares++;
                    $display("FAIL rx_eight: got drop=%0d, expected 0", rx_drop_cnt);
                end
            end
        end
        vectors++;
        if (rx_drop_cnt !== 8'd2 || rx_data !== 16'h0200) begin
            miscompares++;
            $display("FAIL rx_overflow: got drop=%0d rx_data=%h, expected 2 0200", rx_drop_cnt, rx_data);
        end
        // Pop and push together on a full FIFO: the push is kept.
        D_push = 16'h02EE; rx_ready = 1;
        tick();
        rx_ready = 0;
        vectors++;
        if (rx_drop_cnt !== 8'd2 || rx_data !== 16'h0201) begin
            miscompares++;
            $display("FAIL rx_full_pop: got drop=%0d rx_data=%h, expected 2 0201", rx_drop_cnt, rx_data);
        end
        // FIFO is still full: every further push is dropped until saturation.
        D_push = 16'hFF00;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 251) begin
                vectors++;
                if (rx_drop_cnt !== 8'd254) begin
                    miscompares++;
                    $display("FAIL rx_cnt_254: got drop=%0d, expected 254", rx_drop_cnt);
                end
            end
        end
        push = 0;
        vectors++;
        if (rx_drop_cnt !== 8'd255) begin
            miscompares++;
            $display("FAIL rx_cnt_sat: got drop=%0d, expected 255", rx_drop_cnt);
        end
        rx_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            vectors++;
            if (rx_valid !== 1'b1 || rx_data !== ((i == 8) ? 16'h02EE : 16'(16'h0200 + i))) begin
                miscompares++;
                $display("FAIL rx_drain_%0d: got rx_valid=%b rx_data=%h", i, rx_valid, rx_data);
            end
            tick();
        end
        rx_ready = 0;
        vectors++;
        if (rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rx_empty: got rx_valid=%b, expected 0", rx_valid);
        end
        $display("test_rx_overflow done");
    endtask

    task automatic test_underflow_reset();
        pop = 1;
        tick();
        pop = 0;
        vectors++;
        if (err_underflow !== 1'b1 || pndng !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow: got err=%b pndng=%b, expected 1 0", err_underflow, pndng);
        end
        // Write and pop on an empty FIFO: the write survives.
        tx_valid = 1; tx_data = 16'h0A0A; pop = 1;
        tick();
        pop = 0; tx_data = 16'h0B0B;
        push = 1; D_push = 16'h0277;
        vectors++;
        if (pndng !== 1'b1 || D_pop !== 16'h0A0A || err_underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL write_on_underflow: got pndng=%b D_pop=%h err=%b, expected 1 0A0A 1",
                     pndng, D_pop, err_underflow);
        end
        tick();
        tx_valid = 0; push = 0;
        vectors++;
        if (rx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_rx: got rx_valid=%b, expected 1", rx_valid);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({pndng, rx_valid, err_underflow, tx_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL async_reset_flags: got pndng/rx_valid/err/tx_ready=%b, expected 0001",
                     {pndng, rx_valid, err_underflow, tx_ready});
        end
        vectors++;
        if ({D_pop, rx_data, rx_drop_cnt} !== 40'h0) begin
            miscompares++;
            $display("FAIL async_reset_data: got D_pop=%h rx_data=%h drop=%0d, expected all 0",
                     D_pop, rx_data, rx_drop_cnt);
        end
        tick();
        reset = 1'b1;
        tick();
        vectors++;
        if (pndng !== 1'b0 || rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: got pndng=%b rx_valid=%b, expected 0 0", pndng, rx_valid);
        end
        $display("test_underflow_reset done");
    endtask

    initial begin
        #1000000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_tx_order();
        test_tx_full();
        test_back_to_back();
        test_rx_filter();
        test_rx_overflow();
        test_underflow_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_endpoint.md
# bus_endpoint

Device-side endpoint for the shared broadcast bus (`bs_gnrtr_n_rbtr`): the responder end of the pndng/pop/D_pop and push/D_push interface, one instance per driver slot.

- **TX path:** a host-side source writes packets into a TX FIFO. The endpoint advertises them to the bus arbiter with `pndng` and presents the head on `D_pop`. It retires the head on `pop`.
- **RX path:** packets delivered by the bus with `push`/`D_push` are address-filtered, buffered in an RX FIFO, and handed to the host with a valid/ready handshake.

This block replaces the behavioural driver/monitor FIFO model with synthesizable RTL.

## Interface
Parameters:
- `pckg_sz`, 16: packet width in bits. Bits `[pckg_sz-1:pckg_sz-8]` hold the destination ID.
- `depth`, 8: entries per FIFO. Must be a power of two and at least 2.
- `id`, 0: this endpoint's 8-bit address.
- `broadcast`, 8'hFF: destination ID that every endpoint accepts.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pndng`  out  1  TX FIFO non-empty (to bus).
- `D_pop`  out  pckg_sz  TX FIFO head (to bus).
- `pop`  in  1  bus consumed `D_pop` this cycle.
- `push`  in  1  bus delivers `D_push` this cycle.
- `D_push`  in  pckg_sz  delivered packet.
- `tx_valid`  in  1  host offers `tx_data`.
- `tx_ready`  out  1  TX FIFO can accept.
- `tx_data`  in  pckg_sz  host packet.
- `rx_valid`  out  1  RX FIFO non-empty.
- `rx_ready`  in  1  host consumes `rx_data`.
- `rx_data`  out  pckg_sz  RX FIFO head.
- `rx_drop_cnt`  out  8  packets dropped because the RX FIFO was full; saturates at 255.
- `err_underflow`  out  1  sticky: `pop` seen while `pndng` was low.

## Operation
**Reset.** While `reset` is low:
- Both FIFOs are empty; pointers and counts are 0.
- `pndng`=0, `rx_valid`=0, `tx_ready`=1, `D_pop`=0, `rx_data`=0, `rx_drop_cnt`=0, `err_underflow`=0.
- Reset mid-operation discards all buffered packets with no flush. The bus sees `pndng` fall asynchronously.

**TX FIFO.**
- Write when `tx_valid && tx_ready`. `tx_ready` = !tx_full.
- A write while full is impossible by construction.
- Read when `pop && pndng`. `pop` while empty is ignored and sets `err_underflow` until reset.
- Simultaneous write and read on a non-full, non-empty FIFO: occupancy is unchanged.
- Write and `pop` on an empty FIFO in the same cycle: the pop is an underflow. The written packet is retained.

**RX accept.** A packet is accepted when `push` is high and its destination ID equals `id` or `broadcast`. Packets with any other ID are silently ignored and not counted.

**RX FIFO.**
- An accepted packet arriving while the FIFO is full (after applying any same-cycle `rx_ready` pop) is dropped, and `rx_drop_cnt` is incremented, saturating.
- A same-cycle `rx_ready` pop on a full FIFO frees a slot, so the push succeeds.
- `rx_ready` while empty is ignored.

**Pointers.** Pointers are `$clog2(depth)+1` bits. The MSB disambiguates full from empty, and pointers wrap modulo 2·depth.

## Timing
- All state updates on the rising edge of `clk`. Only reset is asynchronous.
- **Host write to bus:** after a host write into an empty TX FIFO at edge N, `pndng`=1 and `D_pop`=packet from edge N (registered-output latency 1).
- **`D_pop` update:** `D_pop` always reflects the current head. After `pop` at edge N it shows the next entry from edge N, or holds its last value with `pndng`=0 if the FIFO is now empty.
- **Bus push to host:** push at edge N gives `rx_valid`=1 and `rx_data` = that packet after edge N.
- **Flag timing:** `tx_ready`, `pndng` and `rx_valid` are derived from registered pointers. There is no combinational path from `pop`/`push`/`tx_valid`/`rx_ready` to any output.
- **Throughput:** sustained throughput is one packet per cycle in each direction simultaneously.

## Structure
- **Package `bus_ep_pkg`:**
  - `ID_W`=8.
  - Function `dest_id(pkt)` extracting the top 8 bits for any `pckg_sz`.
  - Function `is_for_me(pkt, id, broadcast)`.
- **Sub-module `ep_sync_fifo`:** parameterized by width and depth; ports push, pop, din, dout, full, empty, plus a count output. Instantiated twice, once for TX and once for RX.
- **Top level:** the top holds only address filtering, the drop counter and the underflow flag.

## Test plan
- **Reset defaults:** reset low for 3 cycles, then high. Every output takes its reset value; `tx_ready`=1.
- **TX order:** host writes 16'h0201, 16'h0302. `pndng`=1 one cycle after the first write and `D_pop`=16'h0201. `pop`, then `D_pop`=16'h0302. `pop`, then `pndng`=0.
- **TX full:** write 8 packets with no `pop`; `tx_ready`=0 after the 8th. Then drive `pop` and `tx_valid` in the same cycle: `tx_ready` stays 0 and FIFO order is preserved.
- **RX filtering** (`id`=8'h02): push 16'h02AA, 16'hFFBB and 16'h05CC. `rx_data` yields 16'h02AA then 16'hFFBB; 16'h05CC never appears and `rx_drop_cnt`=0.
- **RX overflow:** with `rx_ready`=0, push 10 packets addressed to `id`. 8 are stored and `rx_drop_cnt`=2. Then push with `rx_ready`=1 while full: the packet is accepted and the count stays 2.
- **Underflow and async reset:** `pop` on an empty TX FIFO sets `err_underflow`=1. Asserting `reset` low mid-burst immediately clears `pndng`, `rx_valid` and the flag.
